// File: rtl/icache_pkg.sv
// icache_pkg: geometry constants and FSM encoding for the L1 instruction cache refill controller.
// The FLUSH state exists only when ICACHE_FLUSH_EN is defined.
package icache_pkg;
  localparam int ADDRESS_WIDTH  = 32;
  localparam int CACHE_SIZE     = 65536;
  localparam int WORD_SIZE      = 4;
  localparam int WORD_PER_BLOCK = 16;
  localparam int L2_BUS_WIDTH   = WORD_PER_BLOCK * 8;
  localparam int BLOCK_BITS     = WORD_PER_BLOCK * WORD_SIZE * 8;
  localparam int BEATS          = BLOCK_BITS / L2_BUS_WIDTH;
  localparam int MEMORY_DEPTH   = CACHE_SIZE / (2 * WORD_PER_BLOCK * WORD_SIZE);
  localparam int LINE_SELECT    = $clog2(MEMORY_DEPTH);
  localparam int WORD_SELECT    = $clog2(WORD_PER_BLOCK);
  localparam int BYTE_SELECT    = $clog2(WORD_SIZE);
  localparam int TAG_WIDTH      = ADDRESS_WIDTH - LINE_SELECT - WORD_SELECT - BYTE_SELECT;
  localparam int BLK_WIDTH      = TAG_WIDTH + LINE_SELECT;
  typedef enum logic [2:0] {
    RUN, MISS_REQ, REFILL, WRITE, REPLAY
`ifdef ICACHE_FLUSH_EN
    , FLUSH
`endif
  } state_t;
endpackage

// File: rtl/icache_refill_controller_if.sv
// icache_refill_controller_if: fetch, L2 and cache-RAM signals of the refill controller.
// FLUSH is present only when ICACHE_FLUSH_EN is defined.
interface icache_refill_controller_if;
  import icache_pkg::*;
  logic [ADDRESS_WIDTH-1:0]   PC;
  logic                       PC_VALID, STALL_INSTRUCTION_CACHE, INSTRUCTION_CACHE_READY;
  logic                       TAG_MATCH_WAY0, TAG_MATCH_WAY1, LRU_WAY, HIT, HIT_WAY;
  logic [LINE_SELECT-1:0]     LOOKUP_LINE, WRITE_LINE;
  logic                       ADDRESS_TO_L2_READY_INS, ADDRESS_TO_L2_VALID_INS;
  logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2_INS;
  logic                       DATA_FROM_L2_READY_INS, DATA_FROM_L2_VALID_INS;
  logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2_INS;
  logic [1:0]                 TAG_WRITE_ENABLE, DATA_WRITE_ENABLE;
  logic [TAG_WIDTH-1:0]       TAG_WRITE_DATA;
  logic [BLOCK_BITS-1:0]      BLOCK_WRITE_DATA;
  logic                       LRU_WRITE_ENABLE, LRU_WRITE_DATA;
`ifdef ICACHE_FLUSH_EN
  logic                       FLUSH;
`endif
  modport master (
    input  PC, PC_VALID, STALL_INSTRUCTION_CACHE, TAG_MATCH_WAY0, TAG_MATCH_WAY1, LRU_WAY,
           ADDRESS_TO_L2_READY_INS, DATA_FROM_L2_VALID_INS, DATA_FROM_L2_INS,
`ifdef ICACHE_FLUSH_EN
           FLUSH,
`endif
    output INSTRUCTION_CACHE_READY, HIT, HIT_WAY, LOOKUP_LINE, WRITE_LINE,
           ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_INS, DATA_FROM_L2_READY_INS,
           TAG_WRITE_ENABLE, DATA_WRITE_ENABLE, TAG_WRITE_DATA, BLOCK_WRITE_DATA,
           LRU_WRITE_ENABLE, LRU_WRITE_DATA
  );
  modport slave (
    output PC, PC_VALID, STALL_INSTRUCTION_CACHE, TAG_MATCH_WAY0, TAG_MATCH_WAY1, LRU_WAY,
           ADDRESS_TO_L2_READY_INS, DATA_FROM_L2_VALID_INS, DATA_FROM_L2_INS,
`ifdef ICACHE_FLUSH_EN
           FLUSH,
`endif
    input  INSTRUCTION_CACHE_READY, HIT, HIT_WAY, LOOKUP_LINE, WRITE_LINE,
           ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_INS, DATA_FROM_L2_READY_INS,
           TAG_WRITE_ENABLE, DATA_WRITE_ENABLE, TAG_WRITE_DATA, BLOCK_WRITE_DATA,
           LRU_WRITE_ENABLE, LRU_WRITE_DATA
  );
endinterface

// File: rtl/icache_valid_array.sv
// icache_valid_array: per-way line valid bits with set, line-clear and combinational read.
module icache_valid_array
  import icache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic                   set_way,
  input  logic [LINE_SELECT-1:0] set_line,
  input  logic                   clr_en,
  input  logic [LINE_SELECT-1:0] clr_line,
  input  logic [LINE_SELECT-1:0] rd_line,
  output logic                   rd0,
  output logic                   rd1
);
  logic [1:0][MEMORY_DEPTH-1:0] v_q, v_d;
  assign rd0 = v_q[0][rd_line];
  assign rd1 = v_q[1][rd_line];
  always_comb begin
    v_d = v_q;
    if (clr_en) begin
      v_d[0][clr_line] = 1'b0;
      v_d[1][clr_line] = 1'b0;
    end
    if (set_en) v_d[set_way][set_line] = 1'b1;
  end
  always_ff @(posedge clk) v_q <= rst ? '0 : v_d;
endmodule

// File: rtl/icache_refill_controller.sv
// icache_refill_controller: lookup qualification, victim choice, L2 refill and replay for a 2-way I-cache.
// Define ICACHE_FLUSH_EN to add the FLUSH input and a line-by-line valid flush state.
module icache_refill_controller
  import icache_pkg::*;
(
  input logic CLK,
  input logic RST,
  icache_refill_controller_if.master bus
);
  state_t state_q, state_d;
  logic [BLK_WIDTH-1:0] blk_q, blk_d;
  logic lv_q, lv_d, victim_q, victim_d;
  logic [$clog2(BEATS)-1:0] beat_q, beat_d;
  logic [BLOCK_BITS-1:0] block_q, block_d;
  logic [LINE_SELECT-1:0] line, clr_line;
  logic v0, v1, hit0, hit1, hit, miss, ready, accept, set_en, clr_en, lru_we, lru_wd;
  logic [1:0] we;
`ifdef ICACHE_FLUSH_EN
  logic [LINE_SELECT-1:0] fl_q, fl_d;
  logic fp_q, fp_d;
  assign clr_line = fl_q;
`else
  assign clr_line = line;
`endif
  assign line = blk_q[LINE_SELECT-1:0];
  assign hit0 = bus.TAG_MATCH_WAY0 & v0;
  assign hit1 = bus.TAG_MATCH_WAY1 & v1;
  assign hit  = state_q == RUN && lv_q && (hit0 || hit1);
  assign miss = state_q == RUN && lv_q && !(hit0 || hit1);
  icache_valid_array u_valid (
    .clk(CLK), .rst(RST), .set_en, .set_way(victim_q), .set_line(line),
    .clr_en, .clr_line, .rd_line(line), .rd0(v0), .rd1(v1)
  );
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    lv_d = lv_q;
    victim_d = victim_q;
    beat_d = beat_q;
    block_d = block_q;
    ready = 1'b0;
    accept = 1'b0;
    set_en = 1'b0;
    clr_en = 1'b0;
    lru_we = 1'b0;
    lru_wd = 1'b0;
    we = 2'b00;
`ifdef ICACHE_FLUSH_EN
    fl_d = fl_q;
    fp_d = fp_q | (bus.FLUSH && state_q != FLUSH);
`endif
    case (state_q)
      RUN: begin
        ready = !miss;
`ifdef ICACHE_FLUSH_EN
        if (bus.FLUSH || fp_q) ready = 1'b0;
`endif
        accept = ready && bus.PC_VALID && !bus.STALL_INSTRUCTION_CACHE;
        lv_d = accept || (lv_q && (bus.STALL_INSTRUCTION_CACHE || miss));
        if (accept) blk_d = bus.PC[ADDRESS_WIDTH-1 -: BLK_WIDTH];
        lru_we = hit;
        lru_wd = hit0;
        if (miss) begin
          victim_d = v0 ? (v1 ? bus.LRU_WAY : 1'b1) : 1'b0;
          state_d = MISS_REQ;
        end
`ifdef ICACHE_FLUSH_EN
        else if (bus.FLUSH || fp_q) begin
          state_d = FLUSH;
          lv_d = 1'b0;
          fp_d = 1'b0;
        end
`endif
      end
      MISS_REQ: if (bus.ADDRESS_TO_L2_READY_INS) state_d = REFILL;
      REFILL: if (bus.DATA_FROM_L2_VALID_INS) begin
        block_d[beat_q*L2_BUS_WIDTH +: L2_BUS_WIDTH] = bus.DATA_FROM_L2_INS;
        beat_d = beat_q + 1'b1;
        if (beat_q == $bits(beat_q)'(BEATS-1)) state_d = WRITE;
      end
      WRITE: begin
        we = victim_q ? 2'b10 : 2'b01;
        set_en = 1'b1;
        lru_we = 1'b1;
        lru_wd = !victim_q;
        state_d = REPLAY;
      end
      REPLAY: state_d = RUN;
`ifdef ICACHE_FLUSH_EN
      FLUSH: begin
        clr_en = 1'b1;
        fl_d = fl_q + 1'b1;
        if (fl_q == LINE_SELECT'(MEMORY_DEPTH-1)) state_d = RUN;
      end
`endif
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      blk_q <= '0;
      lv_q <= 1'b0;
      victim_q <= 1'b0;
      beat_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      lv_q <= lv_d;
      victim_q <= victim_d;
      beat_q <= beat_d;
      block_q <= block_d;
    end
  end
`ifdef ICACHE_FLUSH_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fl_q <= '0;
      fp_q <= 1'b0;
    end else begin
      fl_q <= fl_d;
      fp_q <= fp_d;
    end
  end
`endif
  both_ways_hit_a: assert property (@(posedge CLK) disable iff (RST)
    !(state_q == RUN && lv_q && hit0 && hit1));
  assign bus.INSTRUCTION_CACHE_READY = ready;
  assign bus.HIT               = hit;
  assign bus.HIT_WAY           = hit && !hit0;
  assign bus.LOOKUP_LINE       = line;
  assign bus.WRITE_LINE        = line;
  assign bus.ADDRESS_TO_L2_VALID_INS = state_q == MISS_REQ;
  assign bus.ADDRESS_TO_L2_INS = state_q == MISS_REQ ? {blk_q, {WORD_SELECT{1'b0}}} : '0;
  assign bus.DATA_FROM_L2_READY_INS = state_q == REFILL;
  assign bus.TAG_WRITE_ENABLE  = we;
  assign bus.DATA_WRITE_ENABLE = we;
  assign bus.TAG_WRITE_DATA    = blk_q[LINE_SELECT +: TAG_WIDTH];
  assign bus.BLOCK_WRITE_DATA  = block_q;
  assign bus.LRU_WRITE_ENABLE  = lru_we;
  assign bus.LRU_WRITE_DATA    = lru_wd;
endmodule

// File: tb/tb_icache_refill_controller.sv
// tb_icache_refill_controller: directed test of lookup, miss, refill, write, replay and reset for the I-cache controller.
module tb_icache_refill_controller;
  import icache_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [TAG_WIDTH-1:0] tag_mem [2][MEMORY_DEPTH];
  logic lru_mem [MEMORY_DEPTH];
  logic [TAG_WIDTH-1:0] lk_tag = '0;
  icache_refill_controller_if bus ();
  icache_refill_controller dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.TAG_MATCH_WAY0 = tag_mem[0][bus.LOOKUP_LINE] == lk_tag;
  assign bus.TAG_MATCH_WAY1 = tag_mem[1][bus.LOOKUP_LINE] == lk_tag;
  assign bus.LRU_WAY = lru_mem[bus.LOOKUP_LINE];
  always @(posedge clk) begin
    if (bus.PC_VALID && bus.INSTRUCTION_CACHE_READY && !bus.STALL_INSTRUCTION_CACHE)
      lk_tag <= bus.PC[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    for (int w = 0; w < 2; w++)
      if (bus.TAG_WRITE_ENABLE[w]) tag_mem[w][bus.WRITE_LINE] <= bus.TAG_WRITE_DATA;
    if (bus.LRU_WRITE_ENABLE) lru_mem[bus.WRITE_LINE] <= bus.LRU_WRITE_DATA;
  end
`ifdef ICACHE_FLUSH_EN
  initial bus.FLUSH = 1'b0;
`endif
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] beat(input logic [7:0] s, input logic [7:0] k);
    return {4{s, k, 16'hBEEF}};
  endfunction
  function automatic logic [511:0] block(input logic [7:0] s);
    return {beat(s, 8'd3), beat(s, 8'd2), beat(s, 8'd1), beat(s, 8'd0)};
  endfunction
  task automatic lookup(input logic [31:0] pc);
    bus.PC = pc;
    bus.PC_VALID = 1'b1;
    #1;
    chk("accept_ready", bus.INSTRUCTION_CACHE_READY, 1'b1);
    tick();
    bus.PC_VALID = 1'b0;
    #1;
  endtask
  task automatic request(input logic [29:0] addr);
    chk("req_valid", bus.ADDRESS_TO_L2_VALID_INS, 1'b1);
    chk("req_addr", bus.ADDRESS_TO_L2_INS, addr);
    bus.ADDRESS_TO_L2_READY_INS = 1'b1;
    tick();
    bus.ADDRESS_TO_L2_READY_INS = 1'b0;
  endtask
  task automatic refill(input logic [7:0] s, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) begin
        bus.DATA_FROM_L2_VALID_INS = 1'b0;
        #1;
        chk("gap_dready", bus.DATA_FROM_L2_READY_INS, 1'b1);
        tick();
      end
      bus.DATA_FROM_L2_VALID_INS = 1'b1;
      bus.DATA_FROM_L2_INS = beat(s, 8'(k));
      #1;
      chk("beat_dready", bus.DATA_FROM_L2_READY_INS, 1'b1);
      tick();
    end
    bus.DATA_FROM_L2_VALID_INS = 1'b0;
    #1;
  endtask
  task automatic write_replay(input logic way, input logic [8:0] line, input logic [16:0] tag, input logic [7:0] s);
    chk("wr_tag_we", bus.TAG_WRITE_ENABLE, way ? 2'b10 : 2'b01);
    chk("wr_data_we", bus.DATA_WRITE_ENABLE, way ? 2'b10 : 2'b01);
    chk("wr_line", bus.WRITE_LINE, line);
    chk("wr_tag", bus.TAG_WRITE_DATA, tag);
    chk("wr_block", bus.BLOCK_WRITE_DATA, block(s));
    chk("wr_lru_we", bus.LRU_WRITE_ENABLE, 1'b1);
    chk("wr_lru_data", bus.LRU_WRITE_DATA, !way);
    tick();
    chk("replay_ready", bus.INSTRUCTION_CACHE_READY, 1'b0);
    chk("replay_hit", bus.HIT, 1'b0);
    chk("replay_line", bus.LOOKUP_LINE, line);
    tick();
    chk("replay_rehit", bus.HIT, 1'b1);
    chk("replay_hit_way", bus.HIT_WAY, way);
  endtask
  initial begin
    for (int i = 0; i < MEMORY_DEPTH; i++) begin
      tag_mem[0][i] = '0;
      tag_mem[1][i] = '0;
      lru_mem[i] = 1'b0;
    end
    rst = 1'b1;
    bus.PC = '0;
    bus.PC_VALID = 1'b0;
    bus.STALL_INSTRUCTION_CACHE = 1'b0;
    bus.ADDRESS_TO_L2_READY_INS = 1'b0;
    bus.DATA_FROM_L2_VALID_INS = 1'b0;
    bus.DATA_FROM_L2_INS = '0;
    tick();
    tick();
    chk("rst_ready", bus.INSTRUCTION_CACHE_READY, 1'b1);
    chk("rst_hit", bus.HIT, 1'b0);
    chk("rst_hit_way", bus.HIT_WAY, 1'b0);
    chk("rst_avalid", bus.ADDRESS_TO_L2_VALID_INS, 1'b0);
    chk("rst_addr", bus.ADDRESS_TO_L2_INS, 30'h0);
    chk("rst_dready", bus.DATA_FROM_L2_READY_INS, 1'b0);
    chk("rst_tag_we", bus.TAG_WRITE_ENABLE, 2'b00);
    chk("rst_data_we", bus.DATA_WRITE_ENABLE, 2'b00);
    chk("rst_lru_we", bus.LRU_WRITE_ENABLE, 1'b0);
    rst = 1'b0;
    // cold miss: raw tag compare matches (tag 0) but the line is invalid
    lookup(32'h0000_1040);
    chk("cold_hit", bus.HIT, 1'b0);
    chk("cold_ready", bus.INSTRUCTION_CACHE_READY, 1'b0);
    tick();
    request(30'h410);
    refill(8'h11, 1'b0);
    write_replay(1'b0, 9'h041, 17'h0, 8'h11);
    for (int i = 1; i < 3; i++) begin
      bus.PC = 32'h0000_1040 + 32'(4 * i);
      bus.PC_VALID = 1'b1;
      #1;
      chk("b2b_hit", bus.HIT, 1'b1);
      chk("b2b_ready", bus.INSTRUCTION_CACHE_READY, 1'b1);
      chk("b2b_lru_data", bus.LRU_WRITE_DATA, 1'b1);
      tick();
    end
    bus.PC_VALID = 1'b0;
    #1;
    chk("b2b_last_hit", bus.HIT, 1'b1);
    chk("b2b_last_way", bus.HIT_WAY, 1'b0);
    chk("b2b_last_ready", bus.INSTRUCTION_CACHE_READY, 1'b1);
    tick();
    chk("idle_hit", bus.HIT, 1'b0);
    // second way fill with address backpressure, gapped data and stall held
    lookup(32'h0000_9040);
    chk("way1_miss", bus.HIT, 1'b0);
    tick();
    bus.STALL_INSTRUCTION_CACHE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_avalid", bus.ADDRESS_TO_L2_VALID_INS, 1'b1);
      chk("bp_addr", bus.ADDRESS_TO_L2_INS, 30'h2410);
      tick();
    end
    request(30'h2410);
    refill(8'h22, 1'b1);
    write_replay(1'b1, 9'h041, 17'h1, 8'h22);
    chk("way1_lru_data", bus.LRU_WRITE_DATA, 1'b0);
    tick();
    chk("stall_freeze_hit", bus.HIT, 1'b1);
    chk("stall_ready", bus.INSTRUCTION_CACHE_READY, 1'b1);
    bus.STALL_INSTRUCTION_CACHE = 1'b0;
    tick();
    chk("unstall_hit", bus.HIT, 1'b0);
    // third tag on the line, both ways valid, LRU says way0
    lookup(32'h0001_1040);
    chk("lru_miss", bus.HIT, 1'b0);
    tick();
    request(30'h4410);
    refill(8'h33, 1'b0);
    write_replay(1'b0, 9'h041, 17'h2, 8'h33);
    tick();
    // reset in the middle of a refill
    lookup(32'h0000_2080);
    chk("mid_miss", bus.HIT, 1'b0);
    tick();
    request(30'h820);
    for (int k = 0; k < 2; k++) begin
      bus.DATA_FROM_L2_VALID_INS = 1'b1;
      bus.DATA_FROM_L2_INS = beat(8'h44, 8'(k));
      tick();
    end
    bus.DATA_FROM_L2_VALID_INS = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_ready", bus.INSTRUCTION_CACHE_READY, 1'b1);
    chk("mrst_avalid", bus.ADDRESS_TO_L2_VALID_INS, 1'b0);
    chk("mrst_addr", bus.ADDRESS_TO_L2_INS, 30'h0);
    chk("mrst_dready", bus.DATA_FROM_L2_READY_INS, 1'b0);
    chk("mrst_hit", bus.HIT, 1'b0);
    chk("mrst_tag_we", bus.TAG_WRITE_ENABLE, 2'b00);
    chk("mrst_lru_we", bus.LRU_WRITE_ENABLE, 1'b0);
    lookup(32'h0000_2080);
    chk("mrst_valid_clear", bus.HIT, 1'b0);
    chk("mrst_miss_ready", bus.INSTRUCTION_CACHE_READY, 1'b0);
    tick();
    request(30'h820);
    refill(8'h55, 1'b0);
    write_replay(1'b0, 9'h082, 17'h0, 8'h55);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
